// File: rtl/alu_core.sv
// Registered execution-stage ALU: 16 operations on two WIDTH-bit operands,
// result and status flags captured on every rising edge of clk.
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] overflow,
  output logic [WIDTH-1:0] negative,
  output logic [WIDTH-1:0] zero
);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRL  = 4'b0001;
  localparam logic [3:0] OP_SRA  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] WMOD  = WIDTH'(WIDTH);

  // cin carries only a 1-bit carry; the upper bits are don't-care.
  logic unused_cin;
  assign unused_cin = ^cin[WIDTH-1:1];

  // Shifts use one extra bit so the last bit shifted out lands in a fixed
  // position; a full-width b naturally yields 0 / sign-fill for b >= WIDTH.
  logic [WIDTH:0] sll_ext, srl_ext, sra_ext;
  assign sll_ext = {1'b0, a} << b;
  assign srl_ext = {a, 1'b0} >> b;
  assign sra_ext = $signed({a, 1'b0}) >>> b;

  logic [WIDTH-1:0] rot_amt;
  logic [WIDTH-1:0] rol_r, ror_r;
  assign rot_amt = b % WMOD;

  always_comb begin
    rol_r = '0;
    ror_r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int src_l;
      int src_r;
      src_l = i + WIDTH - int'(rot_amt);
      if (src_l >= WIDTH) src_l = src_l - WIDTH;
      src_r = i + int'(rot_amt);
      if (src_r >= WIDTH) src_r = src_r - WIDTH;
      rol_r[i] = a[src_l];
      ror_r[i] = a[src_r];
    end
  end

  // One shared adder serves ADD/SUB/INC/DEC: second operand and carry-in
  // are selected, subtraction is a + ~b + 1.
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic             is_sub;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_b  = b;
    add_ci = cin[0];
    is_sub = 1'b0;
    case (opcode)
      OP_SUB: begin add_b = ~b;   add_ci = 1'b1; is_sub = 1'b1; end
      OP_INC: begin add_b = ONE;  add_ci = 1'b0; end
      OP_DEC: begin add_b = ~ONE; add_ci = 1'b1; is_sub = 1'b1; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

  // add_b already holds the inverted subtrahend, so one same-sign test
  // covers both addition and subtraction overflow.
  logic add_v;
  assign add_v = (a[WIDTH-1] == add_b[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != a[WIDTH-1]);

  logic slt;
  assign slt = $signed(a) < $signed(b);

  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;
  logic             unused_is_sub;
  assign unused_is_sub = is_sub;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (opcode)
      OP_SLL:  begin r = sll_ext[WIDTH-1:0]; c = sll_ext[WIDTH]; end
      OP_SRL:  begin r = srl_ext[WIDTH:1];   c = srl_ext[0];     end
      OP_SRA:  begin r = sra_ext[WIDTH:1];   c = sra_ext[0];     end
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        r = add_sum[WIDTH-1:0];
        c = add_sum[WIDTH];
        v = add_v;
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_NOR:  r = ~(a | b);
      OP_ROL:  r = rol_r;
      OP_ROR:  r = ror_r;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, slt};
      OP_PASS: r = a;
      default: r = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= '0;
      cout     <= '0;
      overflow <= '0;
      negative <= '0;
      zero     <= '0;
    end else begin
      y        <= r;
      cout     <= {{(WIDTH-1){1'b0}}, c};
      overflow <= {{(WIDTH-1){1'b0}}, v};
      negative <= {{(WIDTH-1){1'b0}}, r[WIDTH-1]};
      zero     <= {{(WIDTH-1){1'b0}}, (r == '0)};
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core at WIDTH = 4; expected values are
// hand-computed per vector.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode, a, b, cin;
  logic [3:0] y, cout, overflow, negative, zero;

  int total = 0;
  int bad   = 0;

  alu_core #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b), .cin(cin),
    .y(y), .cout(cout), .overflow(overflow), .negative(negative), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field,
                     input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s: observed %b expected %b", tag, field, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ey,
                         input logic ec, input logic ev,
                         input logic en, input logic ez);
    chk(tag, "y",        y,        ey);
    chk(tag, "cout",     cout,     {3'b000, ec});
    chk(tag, "overflow", overflow, {3'b000, ev});
    chk(tag, "negative", negative, {3'b000, en});
    chk(tag, "zero",     zero,     {3'b000, ez});
  endtask

  task automatic step(input string tag, input logic [3:0] op,
                      input logic [3:0] ia, input logic [3:0] ib,
                      input logic [3:0] ic, input logic [3:0] ey,
                      input logic ec, input logic ev,
                      input logic en, input logic ez);
    opcode = op; a = ia; b = ib; cin = ic;
    @(posedge clk); #1;
    chk_all(tag, ey, ec, ev, en, ez);
  endtask

  initial begin
    rst = 1'b1; opcode = 4'b0011; a = 4'b1111; b = 4'b1111; cin = 4'b0001;
    @(posedge clk); #1;
    chk_all("reset", 4'b0000, 0, 0, 0, 0);
    rst = 1'b0;

    //            tag            op       a        b        cin      y        c  v  n  z
    step("sll_1",      4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0, 0);
    step("add_ovf",    4'b0011, 4'b0111, 4'b0001, 4'b0000, 4'b1000, 0, 1, 1, 0);
    step("add_cin",    4'b0011, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 1);
    step("add_cin_hi", 4'b0011, 4'b0001, 4'b0001, 4'b1110, 4'b0010, 0, 0, 0, 0);
    step("sub_eq",     4'b0100, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 1, 0, 0, 1);
    step("sub_ovf",    4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0111, 1, 1, 0, 0);
    step("sub_borrow", 4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b1111, 0, 0, 1, 0);
    step("sra_2",      4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b1110, 0, 0, 1, 0);
    step("sra_w",      4'b0010, 4'b1010, 4'b0100, 4'b0000, 4'b1111, 1, 0, 1, 0);
    step("sra_big",    4'b0010, 4'b0110, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("sll_w",      4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 1);
    step("sll_0",      4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 0, 0, 1, 0);
    step("sll_big",    4'b0000, 4'b1111, 4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("srl_2",      4'b0001, 4'b1011, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0, 0);
    step("srl_big",    4'b0001, 4'b1011, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("rol_5",      4'b1100, 4'b1001, 4'b0101, 4'b0000, 4'b0011, 0, 0, 0, 0);
    step("ror_1",      4'b1101, 4'b1001, 4'b0001, 4'b0000, 4'b1100, 0, 0, 1, 0);
    step("ror_4",      4'b1101, 4'b1001, 4'b0100, 4'b0000, 4'b1001, 0, 0, 1, 0);
    step("and",        4'b0101, 4'b1100, 4'b1010, 4'b0000, 4'b1000, 0, 0, 1, 0);
    step("or",         4'b0110, 4'b1100, 4'b1010, 4'b0000, 4'b1110, 0, 0, 1, 0);
    step("xor",        4'b0111, 4'b1100, 4'b1010, 4'b0000, 4'b0110, 0, 0, 0, 0);
    step("not",        4'b1000, 4'b1100, 4'b1010, 4'b0000, 4'b0011, 0, 0, 0, 0);
    step("nor",        4'b1001, 4'b1100, 4'b1010, 4'b0000, 4'b0001, 0, 0, 0, 0);
    step("inc_wrap",   4'b1010, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 1);
    step("inc_ovf",    4'b1010, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 0, 1, 1, 0);
    step("dec_wrap",   4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0, 1, 0);
    step("dec_ovf",    4'b1011, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 1, 1, 0, 0);
    step("slt_true",   4'b1110, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0);
    step("slt_false",  4'b1110, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("pass",       4'b1111, 4'b1010, 4'b0101, 4'b0001, 4'b1010, 0, 0, 1, 0);

    // Inputs change mid-cycle; registered outputs must hold until the edge.
    opcode = 4'b0011; a = 4'b0111; b = 4'b0111; cin = 4'b0001;
    #3;
    chk_all("hold", 4'b1010, 0, 0, 1, 0);

    step("add_pre_rst", 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_edge1", 4'b0000, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("rst_edge2", 4'b0000, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("rst_release", 4'b0010, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
